// File: rtl/sqrt_stage.sv
// sqrt_stage: bit-serial fixed-point square root (one root bit per cycle); define SQRT_EARLY_TERM_EN to finish as soon as the root is exact
module sqrt_stage #(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 10,
  localparam int RW = (DATA_W + FRAC_W) / 2,
  localparam int PW = $clog2(RW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_data,
  output logic              out_exact
);
`ifdef SQRT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2*RW-1:0] operand;
  logic [PW-1:0] ptr;
  logic [RW-1:0] guess, root_nx;
  logic [2*RW-1:0] guess_sq, root_sq;
  logic fit, eq;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // trial bit at ptr: keep it when the full-width square still fits under the operand
  always_comb begin
    guess = out_data | (RW'(1) << ptr);
    guess_sq = (2*RW)'(guess) * (2*RW)'(guess);
    fit = guess_sq <= operand;
    eq = guess_sq == operand;
    root_nx = fit ? guess : out_data;
    root_sq = (2*RW)'(root_nx) * (2*RW)'(root_nx);
  end
  // IDLE -> CALC on accept, one root bit per CALC cycle, DONE holds until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      operand <= '0;
      out_data <= '0;
      out_exact <= 1'b0;
      ptr <= PW'(RW - 1);
    end else if (state == IDLE) begin
      if (in_valid) begin
        operand <= {in_data, {FRAC_W{1'b0}}};
        out_data <= '0;
        out_exact <= 1'b0;
        ptr <= PW'(RW - 1);
        state <= CALC;
      end
    end else if (state == CALC) begin
      out_data <= root_nx;
      ptr <= ptr - PW'(1);
      if (ptr == '0 || (EARLY && eq)) begin
        out_exact <= root_sq == operand;
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sqrt_stage.sv
// tb_sqrt_stage: directed and random checks of sqrt_stage against a real-arithmetic square root model
module tb_sqrt_stage;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_exact;
  logic [19:0] in_data;
  logic [14:0] out_data;
  int total = 0;
  int bad = 0;

  sqrt_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exact(out_exact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input logic [19:0] d, output int r, output bit ex, output int lat);
    longint v;
    v = longint'(d) << 10;
    r = int'($floor($sqrt(real'(v))));
    while (longint'(r) * r > v) r--;
    while (longint'(r + 1) * (r + 1) <= v) r++;
    ex = longint'(r) * r == v;
    lat = 15;
`ifdef SQRT_EARLY_TERM_EN
    if (ex && r != 0)
      for (int b = 0; b < 15; b++)
        if (r[b]) begin
          lat = 15 - b;
          break;
        end
`endif
  endfunction

  task automatic do_op(input logic [19:0] d, input int stall, input bit early_rdy);
    int er, el, n;
    bit ex;
    ref_model(d, er, ex, el);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data = d;
    out_ready = early_rdy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(el));
    chk("root", 64'(out_data), 64'(er));
    chk("exact", 64'(out_exact), 64'(ex));
    chk("in_ready_done", 64'(in_ready), 64'(0));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data = 20'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_root", 64'(out_data), 64'(er));
      chk("hold_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b1;
    in_data = 20'($urandom);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("consumed_valid", 64'(out_valid), 64'(0));
    chk("consumed_ready", 64'(in_ready), 64'(1));
    chk("idle_root", 64'(out_data), 64'(er));
    chk("idle_exact", 64'(out_exact), 64'(ex));
  endtask

  initial begin
    int m;
    bit seen;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_exact", 64'(out_exact), 64'(0));
    do_op(20'h01000, 0, 1'b0);
    chk("four_root", 64'(out_data), 64'h0800);
    do_op(20'h00800, 0, 1'b1);
    chk("two_root", 64'(out_data), 64'h05A8);
    do_op(20'hFFFFF, 0, 1'b0);
    chk("max_root", 64'(out_data), 64'h7FFF);
    do_op(20'h00000, 0, 1'b0);
    chk("zero_exact", 64'(out_exact), 64'(1));
    do_op(20'h01000, 5, 1'b0);
    do_op(20'h00800, 0, 1'b0);
    in_valid = 1'b1;
    in_data = 20'h0ABCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(0));
    chk("midrst_out_exact", 64'(out_exact), 64'(0));
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_result", 64'(seen), 64'(0));
    do_op(20'h01000, 0, 1'b0);
    chk("after_rst_root", 64'(out_data), 64'h0800);
    for (int k = 0; k < 30; k++) begin
      m = int'($urandom_range(1023, 0));
      do_op((k % 2 == 0) ? 20'(m * m) : 20'($urandom), (k % 3 == 0) ? int'($urandom_range(3, 1)) : 0,
            (k % 3 != 0) ? 1'($urandom) : 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_stage.md
SQRT_STAGE -- requirements
Module: sqrt_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 20, meaning input width in Q(DATA_W-FRAC_W).FRAC_W fixed point (even).
REQ-002 SHALL have parameter FRAC_W, default 10, meaning input fractional bits (even); root width RW = (DATA_W+FRAC_W)/2 = 15.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream quotient valid.
REQ-006 SHALL have port in_data  input  DATA_W  unsigned Q10.10 radicand (divider quotient).
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port out_valid  output  1  root result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port out_data  output  RW  unsigned Q5.10 root, floor-truncated.
REQ-011 SHALL have port out_exact  output  1  out_data squared equals operand exactly.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL accept on in_valid && in_ready: operand <= {in_data, FRAC_W zeros} (30 bits), out_data <= 0, out_exact <= 0, bit pointer <= RW-1, state <= CALC.
REQ-014 SHALL ignore in_valid outside IDLE; no operand captured, no error.
REQ-015 SHALL per CALC cycle form guess = out_data | (1<<ptr), compute guess*guess at full 2*RW width (no truncation), set bit ptr when guess^2 <= operand, then decrement ptr.
REQ-016 SHALL transition CALC->DONE on the edge processing bit 0; out_valid thus rises 15 edges after the accepting edge (without early termination).
REQ-017 SHALL set out_exact at the edge entering DONE when final out_data^2 == operand (including operand 0 -> root 0, exact 1).
REQ-018 SHALL hold out_data, out_exact and out_valid stable in DONE until out_ready is high; out_valid && out_ready -> IDLE next edge.
REQ-019 SHALL not accept a new operand in the cycle the result is consumed; in_ready first rises the cycle after DONE exits.
REQ-020 SHALL keep out_data/out_exact at last values in IDLE until the next accept.
REQ-021 SHALL tolerate out_ready high before DONE; it has no effect outside DONE.

Reset
REQ-022 SHALL on rst high at any clock edge, including mid-CALC or in DONE, force state IDLE, out_valid 0, in_ready 1 next cycle, out_data 0, out_exact 0, operand 0, ptr RW-1.
REQ-023 SHALL discard any in-flight computation on reset; no result is emitted for it.

Configuration
REQ-024 SHALL with macro SQRT_EARLY_TERM_EN defined, on the CALC cycle where guess^2 == operand, set that bit, set out_exact, and go directly to DONE (latency 15 - ptr edges).
REQ-025 SHALL without SQRT_EARLY_TERM_EN always run all RW CALC cycles; out_data/out_exact values are identical in both builds, only latency differs.

Verification
REQ-026 SHALL test in_data=0x01000 (4.0) -> out_data=0x0800 (2.0), out_exact=1; out_valid 4 edges after accept with SQRT_EARLY_TERM_EN, 15 without.
REQ-027 SHALL test in_data=0x00800 (2.0) -> out_data=0x05A8 (1448), out_exact=0, latency 15 in both builds.
REQ-028 SHALL test in_data=0xFFFFF -> out_data=0x7FFF, out_exact=0; in_data=0x00000 -> out_data=0x0000, out_exact=1, latency 15.
REQ-029 SHALL test backpressure: out_ready low 5 cycles in DONE -> out_valid/out_data held 5 cycles, in_ready low; in_valid pulses meanwhile ignored; out_ready high -> IDLE next edge, next operand accepted after.
REQ-030 SHALL test rst asserted 7 edges into CALC -> IDLE, out_valid 0, out_data 0; a fresh operand 0x01000 then yields 0x0800 correctly.
